// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a single shared ALU. The result sits in
// one output register that can be drained and refilled on the same edge.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             res_zero
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_reg;
  logic             last_id_reg;
  logic [WIDTH-1:0] res_data_reg;
  logic             res_id_reg;
  logic             res_zero_reg;

  logic [1:0]       valid_vec;
  logic [1:0]       ready_vec;
  logic [2:0]       op_arr [2];
  logic [WIDTH-1:0] a_arr  [2];
  logic [WIDTH-1:0] b_arr  [2];

  logic             can_accept;
  logic             accept;
  logic             grant_id;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] alu_next;

  assign valid_vec = {req1_valid, req0_valid};
  assign op_arr[0] = req0_op;
  assign op_arr[1] = req1_op;
  assign a_arr[0]  = req0_a;
  assign a_arr[1]  = req1_a;
  assign b_arr[0]  = req0_b;
  assign b_arr[1]  = req1_b;

  // rst_n gates the handshake so nothing is offered while reset is held.
  assign can_accept = rst_n && ((state_reg == EMPTY) || res_ready);
  assign accept     = can_accept && (|valid_vec);

  always_comb begin
    grant_id = 1'b0;
    if (valid_vec == 2'b11) begin
      grant_id = ~last_id_reg;
    end else if (valid_vec[1]) begin
      grant_id = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = accept && (grant_id == 1'(gi));
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  assign op_sel = op_arr[grant_id];
  assign a_sel  = a_arr[grant_id];
  assign b_sel  = b_arr[grant_id];

  always_comb begin
    alu_next = '0;
    case (op_sel)
      3'd0:    alu_next = ~a_sel;
      3'd1:    alu_next = a_sel & b_sel;
      3'd2:    alu_next = a_sel | b_sel;
      3'd3:    alu_next = a_sel ^ b_sel;
      3'd4:    alu_next = a_sel + b_sel;
      3'd5:    alu_next = a_sel - b_sel;
      3'd6:    alu_next = {{(WIDTH-1){1'b0}}, ($signed(a_sel) < $signed(b_sel))};
      default: alu_next = a_sel;
    endcase
  end

  // last_id only moves on acceptance, so idle cycles keep the current priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      res_data_reg <= '0;
      res_id_reg   <= 1'b0;
      res_zero_reg <= 1'b1;
      last_id_reg  <= 1'b1;
    end else if (accept) begin
      state_reg    <= FULL;
      res_data_reg <= alu_next;
      res_id_reg   <= grant_id;
      res_zero_reg <= (alu_next == '0);
      last_id_reg  <= grant_id;
    end else if (res_ready) begin
      state_reg    <= EMPTY;
    end
  end

  assign res_valid = (state_reg == FULL);
  assign res_data  = res_data_reg;
  assign res_id    = res_id_reg;
  assign res_zero  = res_zero_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Random and directed stimulus for alu_arbiter, checked every cycle against a
// transaction-level model of the arbiter and result register.
module tb_alu_arbiter;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req0_ready;
  logic [2:0]       req0_op = '0;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0;
  logic             req1_valid = 1'b0, req1_ready;
  logic [2:0]       req1_op = '0;
  logic [WIDTH-1:0] req1_a = '0, req1_b = '0;
  logic             res_valid, res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
  logic             res_id, res_zero;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_zero(res_zero)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: one held result plus the index that most recently won.
  logic             m_full;
  logic [WIDTH-1:0] m_data;
  logic             m_id;
  logic             m_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: return a + b;
      3'd5: return a - b;
      3'd6: return (sa < sb) ? 1 : 0;
      default: return a;
    endcase
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_data = '0;
    m_id   = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, res_valid, m_full);
    check({tag, "_data"},  res_data,  m_data);
    check({tag, "_id"},    res_id,    m_id);
    check({tag, "_zero"},  res_zero,  (m_data == 0));
  endtask

  // Called just after a falling edge: drive, check, clock once, update model.
  task automatic step(input string tag,
                      input logic v0, input logic [2:0] op0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                      input logic v1, input logic [2:0] op1, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                      input logic rr);
    logic room, win, take;
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    res_ready  = rr;
    #1;
    room = !m_full || rr;
    win  = (v0 && v1) ? !m_last : v1;
    take = room && (v0 || v1);
    check_outputs(tag);
    check({tag, "_rdy0"}, req0_ready, take && !win);
    check({tag, "_rdy1"}, req1_ready, take && win);
    @(posedge clk);
    if (take) begin
      m_full = 1'b1;
      m_data = win ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
      m_id   = win;
      m_last = win;
      $display("%s: accept id=%0d op=%0d result=%08h", tag, win, win ? op1 : op0, m_data);
    end else begin
      if (rr) m_full = 1'b0;
      $display("%s: no accept full=%0d", tag, m_full);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    check("rst_rdy0", req0_ready, 1'b0);
    check("rst_rdy1", req1_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  logic prev_id;

  initial begin
    @(negedge clk);
    do_reset();

    // NOT of a half-set word, first cycle after reset release.
    step("r030", 1, 3'd0, 32'h0000FFFF, 32'h0, 0, 3'd0, 32'h0, 32'h0, 1);
    check("r030_const_data", res_data, 32'hFFFF0000);
    check("r030_const_id", res_id, 1'b0);

    // Contention at full throughput alternates grants.
    prev_id = res_id;
    for (int i = 0; i < 6; i++) begin
      step("r031", 1, 3'd4, 32'hFFFFFFFF, 32'h1, 1, 3'd5, 32'd5, 32'd7, 1);
      check("r031_alt", res_id, !prev_id);
      check("r031_const", res_data, res_id ? 32'hFFFFFFFE : 32'h0);
      prev_id = res_id;
    end

    // Backpressure holds the result, then drain and refill on one edge.
    for (int i = 0; i < 3; i++)
      step("r032_hold", 1, 3'd1, $urandom, $urandom, 1, 3'd2, $urandom, $urandom, 0);
    step("r032_drain", 1, 3'd3, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 3'd7, 32'h1234, 32'h0, 1);

    step("r033a", 1, 3'd6, 32'h80000000, 32'h1, 0, 3'd0, 32'h0, 32'h0, 1);
    check("r033a_const", res_data, 32'h1);
    step("r033b", 1, 3'd6, 32'h1, 32'h80000000, 0, 3'd0, 32'h0, 32'h0, 1);
    check("r033b_const", res_data, 32'h0);

    // Asynchronous reset while a result is held under backpressure.
    step("r034_hold", 0, 3'd0, 32'h0, 32'h0, 0, 3'd0, 32'h0, 32'h0, 0);
    check("r034_pre_valid", res_valid, 1'b1);
    req0_valid = 1; req1_valid = 1;
    do_reset();
    step("r034_post", 1, 3'd7, 32'h11, 32'h0, 1, 3'd7, 32'h22, 32'h0, 1);
    check("r034_winner", res_id, 1'b0);

    // Two lone requester-1 ops leave requester 0 with priority.
    do_reset();
    step("r035a", 0, 3'd0, 32'h0, 32'h0, 1, 3'd7, 32'h1, 32'h0, 1);
    step("r035b", 0, 3'd0, 32'h0, 32'h0, 1, 3'd7, 32'h2, 32'h0, 1);
    step("r035c", 1, 3'd7, 32'h3, 32'h0, 1, 3'd7, 32'h4, 32'h0, 1);
    check("r035_winner", res_id, 1'b0);

    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(0, 3) != 0), 3'($urandom), rnd_word(), rnd_word(),
           ($urandom_range(0, 3) != 0), 3'($urandom), rnd_word(), rnd_word(),
           ($urandom_range(0, 2) != 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
